// File: rtl/mmio_console_pkg.sv
// Shared definitions for the MMIO console bridge: default MMIO word
// addresses, the bridge FSM state type and the status register layout.
package mmio_console_pkg;

   localparam logic [31:0] CONSOLE_ADDR_DFLT = 32'h0000_1000;
   localparam logic [31:0] STATUS_ADDR_DFLT  = 32'h0000_1004;
   localparam logic [31:0] HALT_ADDR_DFLT    = 32'h0000_1008;

   // Sticky overflow flag position inside the status word.
   localparam int STATUS_OVF_BIT = 31;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;

   // Assemble the status word from the overflow flag and the FIFO count
   // (count arrives zero-extended to 31 bits).
   function automatic logic [31:0] status_word(input logic ovf, input logic [30:0] count);
      logic [31:0] w;
      w = {1'b0, count};
      w[STATUS_OVF_BIT] = ovf;
      return w;
   endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous 8-bit character FIFO. DEPTH must be a power of two so the
// pointers wrap naturally. Head reads as zero whenever the FIFO is empty.
module console_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic [7:0]                   data_i,
   input  logic                         pop_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [7:0]                   head_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   // Full comes straight from the registered count, so a pop cannot make
   // room for a push in the same cycle.
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign count_o = count_q;
   assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

   // Next pointers and occupancy; simultaneous push and pop keep the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   // Pointer and count registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Character storage; contents need no reset since head is masked when empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/mmio_console_bridge.sv
// Bridge between the core bus master and RAM. Decodes a three-word MMIO
// window (console TX, status, halt) and passes every other access through
// combinationally. MMIO accesses take two cycles (busy, then response).
// Build option MMIO_CONSOLE_DROP_EN: console writes to a full FIFO are
// acked and dropped, setting sticky status bit 31, instead of stalling.
module mmio_console_bridge
   import mmio_console_pkg::*;
#(
   parameter logic [31:0] CONSOLE_ADDR = CONSOLE_ADDR_DFLT,
   parameter logic [31:0] STATUS_ADDR  = STATUS_ADDR_DFLT,
   parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DFLT,
   parameter int          DEPTH        = 16,
   parameter bit          BIG_ENDIAN   = 1'b1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_wdata,
   input  logic [3:0]  cpu_byte_en,
   output logic [31:0] cpu_rdata,
   output logic        cpu_busy,
   output logic [31:0] mem_addr,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_byte_en,
   input  logic [31:0] mem_rdata,
   input  logic        mem_busy,
   output logic        char_valid,
   output logic [7:0]  char_data,
   input  logic        char_ready,
   output logic        halt_req,
   output logic [31:0] halt_code
);

   localparam int CW = $clog2(DEPTH+1);

   state_e        state_q, state_d;
   logic [31:0]   rdata_q, rdata_d;
   logic [31:0]   halt_code_q, halt_code_d;
   logic          halt_req_q, halt_req_d;
   logic          hit_con, hit_sta, hit_hlt, hit, req, mmio_sel;
   logic          busy_mmio, push, ovf;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    char_byte;
   logic          char_lane;

   assign hit_con = (cpu_addr[31:2] == CONSOLE_ADDR[31:2]);
   assign hit_sta = (cpu_addr[31:2] == STATUS_ADDR[31:2]);
   assign hit_hlt = (cpu_addr[31:2] == HALT_ADDR[31:2]);
   assign hit     = hit_con | hit_sta | hit_hlt;
   assign req     = cpu_ren | cpu_wen;

   assign char_byte = BIG_ENDIAN ? cpu_wdata[31:24] : cpu_wdata[7:0];
   assign char_lane = BIG_ENDIAN ? cpu_byte_en[3]   : cpu_byte_en[0];

`ifdef MMIO_CONSOLE_DROP_EN
   logic ovf_q, ovf_d;
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   console_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (nRST),
      .push_i  (push),
      .data_i  (char_byte),
      .pop_i   (char_valid & char_ready),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count),
      .head_o  (char_data)
   );

   // Bridge FSM: in IDLE a hit request stalls the core for one cycle and its
   // side effect lands on the IDLE->RESP edge; RESP releases the core.
   always_comb begin
      state_d     = state_q;
      rdata_d     = rdata_q;
      halt_req_d  = halt_req_q;
      halt_code_d = halt_code_q;
      busy_mmio   = 1'b0;
      push        = 1'b0;
`ifdef MMIO_CONSOLE_DROP_EN
      ovf_d       = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (hit && req) begin
               busy_mmio = 1'b1;
               state_d   = RESP;
               rdata_d   = '0;
               if (cpu_wen) begin
                  if (hit_con) begin
                     if (!fifo_full) begin
                        push = char_lane;
                     end else begin
`ifdef MMIO_CONSOLE_DROP_EN
                        ovf_d = ovf_q | char_lane;
`else
                        state_d = IDLE;
`endif
                     end
                  end else if (hit_hlt && (cpu_wdata != '0)) begin
                     halt_req_d  = 1'b1;
                     halt_code_d = cpu_wdata;
                  end
               end else if (hit_sta) begin
                  rdata_d = status_word(ovf, 31'(fifo_count));
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM, response and halt registers; reset discards any pending access.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= IDLE;
         rdata_q     <= '0;
         halt_req_q  <= 1'b0;
         halt_code_q <= '0;
`ifdef MMIO_CONSOLE_DROP_EN
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rdata_q     <= rdata_d;
         halt_req_q  <= halt_req_d;
         halt_code_q <= halt_code_d;
`ifdef MMIO_CONSOLE_DROP_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   // The MMIO side owns the core port during a hit or while responding.
   assign mmio_sel    = hit | (state_q == RESP);
   assign mem_addr    = cpu_addr;
   assign mem_wdata   = cpu_wdata;
   assign mem_byte_en = cpu_byte_en;
   assign mem_ren     = cpu_ren & ~mmio_sel;
   assign mem_wen     = cpu_wen & ~mmio_sel;
   assign cpu_busy    = mmio_sel ? busy_mmio : mem_busy;
   assign cpu_rdata   = mmio_sel ? rdata_q : mem_rdata;
   assign char_valid  = ~fifo_empty;
   assign halt_req    = halt_req_q;
   assign halt_code   = halt_code_q;

endmodule

// File: tb/tb_mmio_console_bridge.sv
// Self-checking bench for mmio_console_bridge: directed scenarios followed by
// randomized bus traffic compared against a transaction-level model (a char
// queue, a halt latch and an overflow flag). Honors MMIO_CONSOLE_DROP_EN.
module tb_mmio_console_bridge;

   localparam logic [31:0] CON   = 32'h0000_1000;
   localparam logic [31:0] STA   = 32'h0000_1004;
   localparam logic [31:0] HLT   = 32'h0000_1008;
   localparam int          DEPTH = 16;

   logic        CLK, nRST;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ren, cpu_wen, cpu_busy;
   logic [3:0]  cpu_byte_en, mem_byte_en;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ren, mem_wen, mem_busy;
   logic        char_valid, char_ready;
   logic [7:0]  char_data;
   logic        halt_req;
   logic [31:0] halt_code;

   mmio_console_bridge #(
      .CONSOLE_ADDR (CON),
      .STATUS_ADDR  (STA),
      .HALT_ADDR    (HLT),
      .DEPTH        (DEPTH),
      .BIG_ENDIAN   (1'b1)
   ) dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .cpu_addr    (cpu_addr),
      .cpu_ren     (cpu_ren),
      .cpu_wen     (cpu_wen),
      .cpu_wdata   (cpu_wdata),
      .cpu_byte_en (cpu_byte_en),
      .cpu_rdata   (cpu_rdata),
      .cpu_busy    (cpu_busy),
      .mem_addr    (mem_addr),
      .mem_ren     (mem_ren),
      .mem_wen     (mem_wen),
      .mem_wdata   (mem_wdata),
      .mem_byte_en (mem_byte_en),
      .mem_rdata   (mem_rdata),
      .mem_busy    (mem_busy),
      .char_valid  (char_valid),
      .char_data   (char_data),
      .char_ready  (char_ready),
      .halt_req    (halt_req),
      .halt_code   (halt_code)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model state.
   logic [7:0]  model_q[$];
   logic        ovf_m;
   logic        halt_req_m;
   logic [31:0] halt_code_m;
   logic        mon_en;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] exp_status();
      return (ovf_m ? 32'h8000_0000 : 32'h0) + 32'(model_q.size());
   endfunction

   function automatic logic [31:0] rand_miss();
      logic [31:0] a;
      a = $urandom;
      if (a[31:4] == 28'h000_0100) a[31] = 1'b1;
      return a;
   endfunction

   // Consumer-side monitor: inputs only change just after posedge, so the
   // values seen here are the ones the next rising edge will act on.
   always @(negedge CLK) begin
      if (mon_en) begin
         check("char_valid", {31'd0, char_valid}, {31'd0, model_q.size() != 0});
         check("char_head", {24'd0, char_data},
               (model_q.size() != 0) ? {24'd0, model_q[0]} : 32'd0);
         if (char_valid && char_ready && model_q.size() != 0) void'(model_q.pop_front());
      end
   end

   // Start an MMIO access from posedge+1; returns one cycle later in RESP.
   task automatic mmio_issue(input logic [31:0] addr, input logic ren, input logic wen,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic chk_rd, input logic [31:0] exp_rd, input string tag);
      cpu_addr = addr; cpu_ren = ren; cpu_wen = wen; cpu_wdata = wdata; cpu_byte_en = be;
      char_ready = 1'b0;
      #1;
      check({tag, "_busy"}, {31'd0, cpu_busy}, 32'd1);
      check({tag, "_memstb"}, {30'd0, mem_ren, mem_wen}, 32'd0);
      @(posedge CLK); #1;
      check({tag, "_ack"}, {31'd0, cpu_busy}, 32'd0);
      if (chk_rd) check({tag, "_rdata"}, cpu_rdata, exp_rd);
      $display("txn %s addr=%h ren=%0d wen=%0d wdata=%h be=%h rdata=%h",
               tag, addr, ren, wen, wdata, be, cpu_rdata);
   endtask

   task automatic mmio_finish();
      cpu_ren = 1'b0; cpu_wen = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic console_write(input logic [31:0] data, input logic [3:0] be, input logic [31:0] lo);
      mmio_issue(CON | lo, 1'b0, 1'b1, data, be, 1'b0, 32'd0, "con_wr");
      if (be[3]) begin
         if (model_q.size() < DEPTH) model_q.push_back(data[31:24]);
         else ovf_m = 1'b1;
      end
      mmio_finish();
   endtask

   task automatic status_read(input string tag);
      mmio_issue(STA | 32'($urandom_range(0, 3)), 1'b1, 1'b0, 32'd0, 4'hF, 1'b1, exp_status(), tag);
      mmio_finish();
   endtask

   task automatic halt_write(input logic [31:0] data);
      mmio_issue(HLT, 1'b0, 1'b1, data, 4'hF, 1'b0, 32'd0, "halt_wr");
      if (data != 32'd0) begin
         halt_req_m  = 1'b1;
         halt_code_m = data;
      end
      check("halt_req", {31'd0, halt_req}, {31'd0, halt_req_m});
      check("halt_code", halt_code, halt_code_m);
      mmio_finish();
   endtask

   task automatic miss_op(input logic [31:0] addr, input logic ren, input logic wen,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] mrd, input logic mb);
      cpu_addr = addr; cpu_ren = ren; cpu_wen = wen; cpu_wdata = wdata; cpu_byte_en = be;
      mem_rdata = mrd; mem_busy = mb; char_ready = 1'b0;
      #1;
      check("miss_addr", mem_addr, addr);
      check("miss_stb", {30'd0, mem_ren, mem_wen}, {30'd0, ren, wen});
      check("miss_wdata", mem_wdata, wdata);
      check("miss_be", {28'd0, mem_byte_en}, {28'd0, be});
      check("miss_rdata", cpu_rdata, mrd);
      check("miss_busy", {31'd0, cpu_busy}, {31'd0, mb});
      $display("txn miss addr=%h ren=%0d wen=%0d rdata=%h busy=%0d", addr, ren, wen, cpu_rdata, cpu_busy);
      @(posedge CLK); #1;
      cpu_ren = 1'b0; cpu_wen = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic drain(input logic rdy);
      char_ready = rdy;
      @(posedge CLK); #1;
      char_ready = 1'b0;
   endtask

   initial begin
      nRST = 1'b0; cpu_addr = STA; cpu_ren = 1'b0; cpu_wen = 1'b0;
      cpu_wdata = 32'd0; cpu_byte_en = 4'h0; mem_rdata = 32'd0; mem_busy = 1'b0;
      char_ready = 1'b0; mon_en = 1'b0;
      ovf_m = 1'b0; halt_req_m = 1'b0; halt_code_m = 32'd0;

      // Reset state.
      repeat (3) @(posedge CLK);
      #1;
      check("rst_rdata", cpu_rdata, 32'd0);
      check("rst_busy", {31'd0, cpu_busy}, 32'd0);
      check("rst_valid", {31'd0, char_valid}, 32'd0);
      check("rst_cdata", {24'd0, char_data}, 32'd0);
      check("rst_halt", {31'd0, halt_req}, 32'd0);
      check("rst_code", halt_code, 32'd0);
      nRST = 1'b1;
      @(posedge CLK); #1;
      mon_en = 1'b1;

      // Passthrough read with RAM busy for two cycles.
      cpu_addr = 32'h0000_0040; cpu_ren = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check("pt_busy_hi", {31'd0, cpu_busy}, 32'd1);
         check("pt_memren", {31'd0, mem_ren}, 32'd1);
         @(posedge CLK); #1;
      end
      mem_busy = 1'b0;
      #1;
      check("pt_busy_lo", {31'd0, cpu_busy}, 32'd0);
      check("pt_rdata", cpu_rdata, 32'hDEAD_BEEF);
      $display("txn passthrough addr=00000040 rdata=%h", cpu_rdata);
      @(posedge CLK); #1;
      cpu_ren = 1'b0;
      status_read("sta_after_pt");

      // Single console character.
      console_write(32'h4100_0000, 4'hF, 32'd0);
      status_read("sta_one");

      // Fill to DEPTH, then one more.
      for (int i = 1; i < DEPTH; i++) console_write({8'(8'h41 + i), 24'h0}, 4'hF, 32'd0);
      status_read("sta_full");
`ifdef MMIO_CONSOLE_DROP_EN
      console_write(32'h5A00_0000, 4'hF, 32'd0);
      status_read("sta_ovf");
`else
      cpu_addr = CON; cpu_ren = 1'b0; cpu_wen = 1'b1; cpu_wdata = 32'h5A00_0000; cpu_byte_en = 4'hF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_busy", {31'd0, cpu_busy}, 32'd1);
         @(posedge CLK); #1;
      end
      char_ready = 1'b1;
      #1;
      check("stall_busy_pop", {31'd0, cpu_busy}, 32'd1);
      @(posedge CLK); #1;
      char_ready = 1'b0;
      #1;
      check("stall_busy_after", {31'd0, cpu_busy}, 32'd1);
      @(posedge CLK); #1;
      check("stall_ack", {31'd0, cpu_busy}, 32'd0);
      model_q.push_back(8'h5A);
      $display("txn con_wr17 addr=%h acked after pop", cpu_addr);
      mmio_finish();
      status_read("sta_full2");
`endif
      for (int g = 0; g < 40 && model_q.size() != 0; g++) drain(1'b1);
      status_read("sta_drained");

      // Halt register.
      halt_write(32'd0);
      halt_write(32'd1);
      halt_write(32'd0);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1: miss_op(rand_miss(), 1'($urandom), 1'($urandom), $urandom, 4'($urandom),
                          $urandom, 1'($urandom));
            2, 3: begin
`ifndef MMIO_CONSOLE_DROP_EN
               for (int g = 0; g < 4 && model_q.size() >= DEPTH; g++) drain(1'b1);
`endif
               console_write($urandom, ($urandom_range(0, 3) != 0) ? 4'h8 | 4'($urandom) : 4'($urandom) & 4'h7,
                             32'($urandom_range(0, 3)));
            end
            4: status_read("sta_rd");
            5: begin
               mmio_issue(STA, 1'b0, 1'b1, $urandom, 4'hF, 1'b0, 32'd0, "sta_wr");
               mmio_finish();
            end
            6: halt_write(($urandom_range(0, 2) == 0) ? 32'd0 : $urandom);
            7: begin
               mmio_issue(($urandom_range(0, 1) != 0) ? CON : HLT, 1'b1, 1'b0, 32'd0, 4'hF,
                          1'b1, 32'd0, "wo_rd");
               mmio_finish();
            end
            8: begin
               mmio_issue(STA, 1'b1, 1'b1, $urandom, 4'hF, 1'b1, 32'd0, "rw_both");
               mmio_finish();
            end
            default: begin
               for (int k = 0; k < $urandom_range(1, 3); k++) drain(1'($urandom));
            end
         endcase
      end
      status_read("sta_rand_end");

      // Reset while responding with three characters queued.
      for (int g = 0; g < 40 && model_q.size() != 0; g++) drain(1'b1);
      console_write(32'h6100_0000, 4'hF, 32'd0);
      console_write(32'h6200_0000, 4'hF, 32'd0);
      mmio_issue(CON, 1'b0, 1'b1, 32'h6300_0000, 4'hF, 1'b0, 32'd0, "con_rst");
      model_q.push_back(8'h63);
      check("pre_rst_halt", {31'd0, halt_req}, {31'd0, halt_req_m});
      mon_en = 1'b0;
      nRST = 1'b0; cpu_wen = 1'b0;
      @(posedge CLK); #1;
      check("mid_rst_busy", {31'd0, cpu_busy}, 32'd0);
      check("mid_rst_valid", {31'd0, char_valid}, 32'd0);
      check("mid_rst_rdata", cpu_rdata, 32'd0);
      check("mid_rst_halt", {31'd0, halt_req}, 32'd0);
      check("mid_rst_code", halt_code, 32'd0);
      model_q.delete();
      ovf_m = 1'b0; halt_req_m = 1'b0; halt_code_m = 32'd0;
      nRST = 1'b1;
      @(posedge CLK); #1;
      mon_en = 1'b1;
      status_read("sta_post_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
